// File: rtl/tile_host_controller.sv
// tile_host_controller
//
// Sequences a RISC-V tile through one run: holds the tile in reset for a
// programmed number of cycles, optionally delivers a single fromhost word,
// then lets the tile run while watching tohost for a pass/fail code or a
// cycle-budget timeout. Completion status is sticky until the next start
// or an abort.
//
// Ports:
//   clock              sole clock, rising edge
//   reset              asynchronous, active-high controller reset
//   start              single-cycle run request (accepted in IDLE or DONE)
//   abort              return to IDLE from any state, wins over start
//   host_write_en      sampled with start: deliver host_word before RUN
//   host_word          fromhost value, sampled with start
//   tile_reset         reset to the tile
//   io_fromhost_valid  one-cycle fromhost strobe to the tile
//   io_fromhost_bits   fromhost data to the tile
//   io_tohost          tohost word from the tile
//   done/pass/fail/timeout  sticky completion flags
//   exit_code          io_tohost >> 1 captured on fail, else 0
//   cycle_count        RUN cycles elapsed in the current/last run
module tile_host_controller #(
  parameter int unsigned RESET_CYCLES = 5,
  parameter int unsigned TIMEOUT      = 1000000,
  parameter int unsigned XLEN         = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic            abort,
  input  logic            host_write_en,
  input  logic [XLEN-1:0] host_word,
  output logic            tile_reset,
  output logic            io_fromhost_valid,
  output logic [XLEN-1:0] io_fromhost_bits,
  input  logic [XLEN-1:0] io_tohost,
  output logic            done,
  output logic            pass,
  output logic            fail,
  output logic            timeout,
  output logic [XLEN-1:0] exit_code,
  output logic [31:0]     cycle_count
);

  typedef enum logic [2:0] {
    IDLE,
    RESET_TILE,
    HOST_WRITE,
    RUN,
    DONE
  } state_t;

  localparam logic [7:0]  RESET_LAST  = 8'(RESET_CYCLES - 1);
  localparam logic [32:0] TIMEOUT_EXT = 33'(TIMEOUT);

  state_t            state;
  logic [7:0]        reset_cnt;
  logic              host_write_en_q;
  logic [XLEN-1:0]   host_word_q;

  // The +1 is done in 33 bits so a saturated count can never wrap around
  // and falsely match the budget.
  logic              budget_hit;
  assign budget_hit = ({1'b0, cycle_count} + 33'd1) == TIMEOUT_EXT;

  // Single sequencing FSM. Every output is a register updated alongside the
  // state so nothing combinational reaches the ports.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      reset_cnt         <= '0;
      host_write_en_q   <= 1'b0;
      host_word_q       <= '0;
      tile_reset        <= 1'b1;
      io_fromhost_valid <= 1'b0;
      io_fromhost_bits  <= '0;
      done              <= 1'b0;
      pass              <= 1'b0;
      fail              <= 1'b0;
      timeout           <= 1'b0;
      exit_code         <= '0;
      cycle_count       <= '0;
    end else if (abort) begin
      state             <= IDLE;
      tile_reset        <= 1'b1;
      io_fromhost_valid <= 1'b0;
      io_fromhost_bits  <= '0;
      done              <= 1'b0;
      pass              <= 1'b0;
      fail              <= 1'b0;
      timeout           <= 1'b0;
      exit_code         <= '0;
      cycle_count       <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state           <= RESET_TILE;
            reset_cnt       <= '0;
            host_write_en_q <= host_write_en;
            host_word_q     <= host_word;
            tile_reset      <= 1'b1;
            done            <= 1'b0;
            pass            <= 1'b0;
            fail            <= 1'b0;
            timeout         <= 1'b0;
            exit_code       <= '0;
            cycle_count     <= '0;
          end
        end

        RESET_TILE: begin
          // The counter starts at 0 on entry, so matching RESET_LAST means
          // exactly RESET_CYCLES cycles have been spent here.
          if (reset_cnt == RESET_LAST) begin
            tile_reset <= 1'b0;
            if (host_write_en_q) begin
              state             <= HOST_WRITE;
              io_fromhost_valid <= 1'b1;
              io_fromhost_bits  <= host_word_q;
            end else begin
              state <= RUN;
            end
          end else begin
            reset_cnt <= reset_cnt + 8'd1;
          end
        end

        HOST_WRITE: begin
          state             <= RUN;
          io_fromhost_valid <= 1'b0;
          io_fromhost_bits  <= '0;
        end

        RUN: begin
          if (cycle_count != '1) begin
            cycle_count <= cycle_count + 32'd1;
          end
          // A tohost result on the same cycle as the budget wins.
          if (io_tohost == XLEN'(1)) begin
            state      <= DONE;
            tile_reset <= 1'b1;
            done       <= 1'b1;
            pass       <= 1'b1;
          end else if (io_tohost > XLEN'(1)) begin
            state      <= DONE;
            tile_reset <= 1'b1;
            done       <= 1'b1;
            fail       <= 1'b1;
            exit_code  <= io_tohost >> 1;
          end else if (budget_hit) begin
            state      <= DONE;
            tile_reset <= 1'b1;
            done       <= 1'b1;
            timeout    <= 1'b1;
          end
        end

        default: begin
          state      <= IDLE;
          tile_reset <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tile_host_controller.sv
// tb_tile_host_controller
//
// Drives two controller instances: one with default parameters and one with
// a 50-cycle budget for the timeout runs. A table of run records is applied
// in a loop; each run pushes its expected result onto a scoreboard queue,
// which is popped and compared when the controller reports done. Hand-written
// sequences cover restart from DONE, abort, and asynchronous reset.
module tb_tile_host_controller;

  localparam int XLEN = 32;

  logic            clock = 1'b0;
  logic            reset;
  logic            start_a;
  logic            start_b;
  logic            abort;
  logic            host_write_en;
  logic [XLEN-1:0] host_word;
  logic [XLEN-1:0] io_tohost;

  logic            tile_reset_a, valid_a, done_a, pass_a, fail_a, timeout_a;
  logic [XLEN-1:0] bits_a, exit_a;
  logic [31:0]     cycles_a;
  logic            tile_reset_b, valid_b, done_b, pass_b, fail_b, timeout_b;
  logic [XLEN-1:0] bits_b, exit_b;
  logic [31:0]     cycles_b;

  // Monitored view of whichever instance the current run uses.
  logic            sel_b;
  logic            m_tile_reset, m_valid, m_done, m_pass, m_fail, m_timeout;
  logic [XLEN-1:0] m_bits, m_exit;
  logic [31:0]     m_cycles;

  assign m_tile_reset = sel_b ? tile_reset_b : tile_reset_a;
  assign m_valid      = sel_b ? valid_b      : valid_a;
  assign m_bits       = sel_b ? bits_b       : bits_a;
  assign m_done       = sel_b ? done_b       : done_a;
  assign m_pass       = sel_b ? pass_b       : pass_a;
  assign m_fail       = sel_b ? fail_b       : fail_a;
  assign m_timeout    = sel_b ? timeout_b    : timeout_a;
  assign m_exit       = sel_b ? exit_b       : exit_a;
  assign m_cycles     = sel_b ? cycles_b     : cycles_a;

  always #5 clock = ~clock;

  tile_host_controller dut_a (
    .clock             (clock),
    .reset             (reset),
    .start             (start_a),
    .abort             (abort),
    .host_write_en     (host_write_en),
    .host_word         (host_word),
    .tile_reset        (tile_reset_a),
    .io_fromhost_valid (valid_a),
    .io_fromhost_bits  (bits_a),
    .io_tohost         (io_tohost),
    .done              (done_a),
    .pass              (pass_a),
    .fail              (fail_a),
    .timeout           (timeout_a),
    .exit_code         (exit_a),
    .cycle_count       (cycles_a)
  );

  tile_host_controller #(.RESET_CYCLES(5), .TIMEOUT(50), .XLEN(XLEN)) dut_b (
    .clock             (clock),
    .reset             (reset),
    .start             (start_b),
    .abort             (abort),
    .host_write_en     (host_write_en),
    .host_word         (host_word),
    .tile_reset        (tile_reset_b),
    .io_fromhost_valid (valid_b),
    .io_fromhost_bits  (bits_b),
    .io_tohost         (io_tohost),
    .done              (done_b),
    .pass              (pass_b),
    .fail              (fail_b),
    .timeout           (timeout_b),
    .exit_code         (exit_b),
    .cycle_count       (cycles_b)
  );

  typedef struct {
    bit          use_b;
    bit          hwe;
    logic [31:0] word;
    int          term;
    logic [31:0] term_val;
    bit          start_in_run;
    bit          exp_pass;
    bit          exp_fail;
    bit          exp_timeout;
    logic [31:0] exp_exit;
    logic [31:0] exp_cycles;
  } vec_t;

  typedef struct {
    bit          pass;
    bit          fail;
    bit          timeout;
    logic [31:0] exit_code;
    logic [31:0] cycles;
  } exp_t;

  vec_t vecs[9];
  exp_t sb_q[$];
  int   checks = 0;
  int   passed = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Pops the oldest expected result and compares it with the finished run.
  task automatic scoreboardCheck();
    exp_t e;
    if (sb_q.size() == 0) begin
      checkOutput("scoreboard_empty", 1, 0);
      return;
    end
    e = sb_q.pop_front();
    checkOutput("pass",        m_pass,    e.pass);
    checkOutput("fail",        m_fail,    e.fail);
    checkOutput("timeout",     m_timeout, e.timeout);
    checkOutput("exit_code",   m_exit,    e.exit_code);
    checkOutput("cycle_count", m_cycles,  e.cycles);
  endtask

  // Runs one table record from start pulse to done, checking the reset
  // phase, the optional fromhost strobe and the sticky result.
  task automatic applyStimulus(input vec_t v);
    int c;
    sel_b = v.use_b;
    sb_q.push_back('{v.exp_pass, v.exp_fail, v.exp_timeout, v.exp_exit, v.exp_cycles});
    host_write_en = v.hwe;
    host_word     = v.word;
    if (v.use_b) start_b = 1'b1;
    else         start_a = 1'b1;
    step();
    start_a = 1'b0;
    start_b = 1'b0;
    host_write_en = 1'b0;
    host_word     = '0;
    checkOutput("start_clears_done",   m_done,   0);
    checkOutput("start_clears_cycles", m_cycles, 0);
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("tile_reset_hold_%0d", i), m_tile_reset, 1);
      step();
    end
    checkOutput("tile_reset_release", m_tile_reset, 0);
    if (v.hwe) begin
      checkOutput("fromhost_valid_high", m_valid, 1);
      checkOutput("fromhost_bits",       m_bits,  v.word);
      step();
      checkOutput("fromhost_valid_low",  m_valid,      0);
      checkOutput("fromhost_bits_clear", m_bits,       0);
      checkOutput("run_tile_reset_low",  m_tile_reset, 0);
    end else begin
      checkOutput("no_fromhost_strobe", m_valid, 0);
    end
    checkOutput("run_entry_cycles", m_cycles, 0);
    c = 1;
    while (!m_done && c <= 200) begin
      io_tohost = (c == v.term) ? v.term_val : 32'h0;
      if (v.start_in_run && (c == 3 || c == 7)) begin
        if (v.use_b) start_b = 1'b1;
        else         start_a = 1'b1;
      end
      step();
      start_a = 1'b0;
      start_b = 1'b0;
      c++;
    end
    io_tohost = '0;
    checkOutput("run_ended", m_done, 1);
    checkOutput("done_tile_reset", m_tile_reset, 1);
    scoreboardCheck();
    step();
    checkOutput("done_sticky",   m_done,   1);
    checkOutput("cycles_sticky", m_cycles, v.exp_cycles);
  endtask

  initial begin
    //          use_b hwe word          term tval          sir pass fail tmo exit           cycles
    vecs[0] = '{1'b0, 1'b0, 32'h0,        100, 32'h1,        1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        32'd100};
    vecs[1] = '{1'b0, 1'b0, 32'h0,        20,  32'h7,        1'b0, 1'b0, 1'b1, 1'b0, 32'h3,        32'd20};
    vecs[2] = '{1'b1, 1'b0, 32'h0,        0,   32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 32'h0,        32'd50};
    vecs[3] = '{1'b1, 1'b0, 32'h0,        50,  32'h1,        1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        32'd50};
    vecs[4] = '{1'b0, 1'b1, 32'hDEADBEEF, 5,   32'h1,        1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        32'd5};
    vecs[5] = '{1'b0, 1'b0, 32'h0,        15,  32'h10,       1'b1, 1'b0, 1'b1, 1'b0, 32'h8,        32'd15};
    vecs[6] = '{1'b0, 1'b0, 32'h0,        1,   32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 1'b0, 32'h7FFFFFFF, 32'd1};
    vecs[7] = '{1'b0, 1'b0, 32'h0,        3,   32'h1,        1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        32'd3};
    vecs[8] = '{1'b0, 1'b1, 32'hCAFEF00D, 10,  32'h1,        1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        32'd10};

    reset = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    abort = 1'b0;
    host_write_en = 1'b0;
    host_word = '0;
    io_tohost = '0;
    sel_b = 1'b0;
    #3;
    checkOutput("reset_tile_reset", tile_reset_a, 1);
    checkOutput("reset_done",       done_a,       0);
    checkOutput("reset_valid",      valid_a,      0);
    checkOutput("reset_cycles",     cycles_a,     0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    step();

    for (int i = 0; i < 7; i++) begin
      $display("[TB] run vector %0d", i);
      applyStimulus(vecs[i]);
    end

    // Restart from DONE: flags from the previous failing run clear at once.
    sel_b = 1'b0;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    checkOutput("restart_done",       done_a,       0);
    checkOutput("restart_fail",       fail_a,       0);
    checkOutput("restart_exit",       exit_a,       0);
    checkOutput("restart_tile_reset", tile_reset_a, 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    checkOutput("abort_tile_reset", tile_reset_a, 1);
    repeat (8) step();
    checkOutput("abort_stays_idle", tile_reset_a, 1);

    // Abort and start together in DONE: abort wins, no run begins.
    applyStimulus(vecs[7]);
    abort = 1'b1;
    start_a = 1'b1;
    step();
    abort = 1'b0;
    start_a = 1'b0;
    checkOutput("abort_start_done",   done_a,   0);
    checkOutput("abort_start_pass",   pass_a,   0);
    checkOutput("abort_start_cycles", cycles_a, 0);
    repeat (8) step();
    checkOutput("abort_start_idle", tile_reset_a, 1);

    // Asynchronous reset in the middle of RUN cycle 30.
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    repeat (5) step();
    repeat (29) step();
    checkOutput("mid_run_cycles", cycles_a, 29);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_run_tile_reset", tile_reset_a, 1);
    checkOutput("async_run_cycles",     cycles_a,     0);
    @(negedge clock);
    reset = 1'b0;
    step();

    // Asynchronous reset while the fromhost strobe is high.
    host_write_en = 1'b1;
    host_word = 32'h12345678;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    host_write_en = 1'b0;
    host_word = '0;
    repeat (5) step();
    checkOutput("hw_strobe_before_reset", valid_a, 1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_hw_valid",      valid_a,      0);
    checkOutput("async_hw_bits",       bits_a,       0);
    checkOutput("async_hw_tile_reset", tile_reset_a, 1);
    @(negedge clock);
    reset = 1'b0;
    step();
    applyStimulus(vecs[8]);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish, got running, expected finished");
    $fatal(1, "[TB] time limit reached");
  end

endmodule
